// File: rtl/tt_tx_sched.sv
// tt_tx_sched: shares one tt_uart transmitter between the console output
// (port A) and the debug monitor (port B). Round-robin arbitration with a
// per-port lock, load handshake against tx_empty, and a load watchdog.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for an eligible requester while the UART is empty
// ST_LOAD    | ld_tx_data high, waiting for the UART to drop tx_empty
// ST_WAIT    | UART took the byte, waiting for tx_empty to return high

module tt_tx_sched #(
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_valid,
   input  logic [7:0] a_data,
   input  logic       a_lock,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_data,
   input  logic       b_lock,
   output logic       b_ready,
   output logic       ld_tx_data,
   output logic [7:0] tx_data,
   input  logic       tx_empty,
   output logic       gnt,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Last counter value still allowed in LOAD before the byte is abandoned.
   localparam logic [15:0] CNT_LAST = TIMEOUT - 16'd1;

   state_t      state_q, state_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        gnt_q, gnt_d;
   logic        lock_held_q, lock_held_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic owner_lock;
   logic owner_only;
   logic cand_a;
   logic cand_b;
   logic pick_b;
   logic accept;

   // Arbitration: a held lock narrows eligibility to the owner while the
   // owner keeps its lock input high; ties go to the port not served last.
   always_comb begin
      owner_lock = gnt_q ? b_lock : a_lock;
      owner_only = lock_held_q & owner_lock;
      cand_a     = a_valid & tx_empty & (~owner_only | ~gnt_q);
      cand_b     = b_valid & tx_empty & (~owner_only | gnt_q);
      pick_b     = (cand_a & cand_b) ? ~gnt_q : cand_b;
      accept     = (state_q == ST_IDLE) & ~reset & (cand_a | cand_b);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tx_data_q   <= 8'h00;
         gnt_q       <= 1'b1;
         lock_held_q <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         gnt_q       <= gnt_d;
         lock_held_q <= lock_held_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      gnt_d       = gnt_q;
      lock_held_d = lock_held_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (lock_held_q & ~owner_lock) begin
               lock_held_d = 1'b0;
            end
            if (accept) begin
               state_d     = ST_LOAD;
               tx_data_d   = pick_b ? b_data : a_data;
               gnt_d       = pick_b;
               lock_held_d = pick_b ? b_lock : a_lock;
               cnt_d       = 16'd0;
            end
         end
         ST_LOAD: begin
            cnt_d = cnt_q + 16'd1;
            if (!tx_empty) begin
               state_d = ST_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               // UART never took the byte: drop it and release any lock.
               err_d       = 1'b1;
               lock_held_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (tx_empty) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state plus the combinational handshake.
   always_comb begin
      ld_tx_data = (state_q == ST_LOAD);
      busy       = (state_q != ST_IDLE);
      a_ready    = accept & ~pick_b;
      b_ready    = accept & pick_b;
   end

   assign tx_data = tx_data_q;
   assign gnt     = gnt_q;
   assign err     = err_q;

endmodule

// File: tb/tb_tt_tx_sched.sv
// Testbench for tt_tx_sched: queue-driven sources, a simple UART model and
// a scoreboard fed from a transaction-level model of the arbitration rules.

module tb_tt_tx_sched;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } src_t;

   typedef struct packed {
      logic [7:0] d;
      logic       g;
   } exp_t;

   localparam int UM_NORM  = 0;
   localparam int UM_STUCK = 1;
   localparam int UM_BUSY  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_valid, a_lock, b_valid, b_lock, tx_empty;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready, ld_tx_data, gnt, busy, err;
   logic [7:0] tx_data;

   logic       t1_a_valid, t1_a_lock, t1_b_valid, t1_b_lock, t1_tx_empty;
   logic [7:0] t1_a_data, t1_b_data;
   logic       t1_a_ready, t1_b_ready, t1_ld, t1_gnt, t1_busy, t1_err;
   logic [7:0] t1_tx_data;

   src_t qa[$];
   src_t qb[$];
   exp_t exp_q[$];

   int   checks = 0;
   int   errors = 0;
   int   loads  = 0;
   int   uart_mode = UM_NORM;
   int   fix_drop = 0;
   int   fix_busy = 0;
   int   dly_max = 3;
   int   busy_max = 4;
   logic a_lock_idle = 1'b0;

   tt_tx_sched #(.TIMEOUT(16'd8)) u_dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_lock(a_lock), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_lock(b_lock), .b_ready(b_ready),
      .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_empty(tx_empty),
      .gnt(gnt), .busy(busy), .err(err)
   );

   tt_tx_sched #(.TIMEOUT(16'd1)) u_dut1 (
      .clk(clk), .reset(reset),
      .a_valid(t1_a_valid), .a_data(t1_a_data), .a_lock(t1_a_lock), .a_ready(t1_a_ready),
      .b_valid(t1_b_valid), .b_data(t1_b_data), .b_lock(t1_b_lock), .b_ready(t1_b_ready),
      .ld_tx_data(t1_ld), .tx_data(t1_tx_data), .tx_empty(t1_tx_empty),
      .gnt(t1_gnt), .busy(t1_busy), .err(t1_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Expected load order derived from the arbitration rules, one grant at a
   // time, for sources that present their next byte whenever they have one.
   task automatic model_order(input src_t ma[$], input src_t mb[$]);
      logic last;
      logic held;
      logic pick;
      logic own_l;
      src_t s;
      last = 1'b1;
      held = 1'b0;
      while (ma.size() + mb.size() > 0) begin
         own_l = 1'b0;
         if (!last && ma.size() > 0) own_l = ma[0].l;
         if (last && mb.size() > 0) own_l = mb[0].l;
         if (held && own_l) pick = last;
         else if (ma.size() > 0 && mb.size() > 0) pick = ~last;
         else pick = (mb.size() > 0);
         if (pick) s = mb.pop_front();
         else s = ma.pop_front();
         exp_q.push_back({s.d, pick});
         held = s.l;
         last = pick;
      end
   endtask

   // Source ports and UART model: inputs change just after the rising edge.
   initial begin : driver
      logic take_a, take_b;
      int   u_phase, u_cnt;
      a_valid = 1'b0; a_data = 8'h00; a_lock = 1'b0;
      b_valid = 1'b0; b_data = 8'h00; b_lock = 1'b0;
      tx_empty = 1'b1;
      u_phase = 0; u_cnt = 0;
      forever begin
         @(negedge clk);
         take_a = a_valid & a_ready;
         take_b = b_valid & b_ready;
         @(posedge clk);
         #1;
         if (take_a && qa.size() > 0) void'(qa.pop_front());
         if (take_b && qb.size() > 0) void'(qb.pop_front());
         a_valid = 1'b0; a_data = 8'h00; a_lock = a_lock_idle;
         if (qa.size() > 0) begin
            a_valid = 1'b1; a_data = qa[0].d; a_lock = qa[0].l;
         end
         b_valid = 1'b0; b_data = 8'h00; b_lock = 1'b0;
         if (qb.size() > 0) begin
            b_valid = 1'b1; b_data = qb[0].d; b_lock = qb[0].l;
         end
         if (uart_mode == UM_STUCK) begin
            tx_empty = 1'b1; u_phase = 0;
         end else if (uart_mode == UM_BUSY) begin
            tx_empty = 1'b0; u_phase = 0;
         end else begin
            case (u_phase)
               0: begin
                  tx_empty = 1'b1;
                  if (ld_tx_data) begin
                     u_cnt = (fix_drop != 0) ? fix_drop : int'($urandom_range(1, dly_max));
                     u_phase = 1;
                  end
               end
               1: begin
                  u_cnt--;
                  if (u_cnt == 0) begin
                     tx_empty = 1'b0;
                     u_cnt = (fix_busy != 0) ? fix_busy : int'($urandom_range(1, busy_max));
                     u_phase = 2;
                  end
               end
               default: begin
                  u_cnt--;
                  if (u_cnt == 0) begin
                     tx_empty = 1'b1;
                     u_phase = 0;
                  end
               end
            endcase
         end
      end
   end

   // Scoreboard monitor: every rising ld_tx_data is one load to account for.
   initial begin : monitor
      logic       ld_prev;
      logic [7:0] held_d;
      exp_t       e;
      ld_prev = 1'b0;
      held_d = 8'h00;
      forever begin
         @(negedge clk);
         if (ld_tx_data && !ld_prev) begin
            loads++;
            chk("load_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("load_data", 32'(tx_data), 32'(e.d));
               chk("load_gnt", 32'(gnt), 32'(e.g));
            end
            held_d = tx_data;
         end else if (ld_tx_data) begin
            chk("tx_data_stable", 32'(tx_data), 32'(held_d));
         end
         ld_prev = ld_tx_data;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      logic done;
      done = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (qa.size() == 0 && qb.size() == 0 && exp_q.size() == 0 && !busy && tx_empty) begin
            done = 1'b1;
            break;
         end
      end
      chk(nm, 32'(done), 32'd1);
   endtask

   initial begin : main
      int   base;
      logic got;
      int   na, nb;
      src_t ma[$];
      src_t mb[$];
      src_t s;

      reset = 1'b1;
      t1_a_valid = 1'b0; t1_a_data = 8'h00; t1_a_lock = 1'b0;
      t1_b_valid = 1'b0; t1_b_data = 8'h00; t1_b_lock = 1'b0;
      t1_tx_empty = 1'b1;

      // Reset values, readies held low during reset, A wins the first tie.
      qa.push_back({8'h12, 1'b0});
      qb.push_back({8'h34, 1'b0});
      exp_q.push_back({8'h12, 1'b0});
      exp_q.push_back({8'h34, 1'b1});
      repeat (2) @(negedge clk);
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      chk("rst_ld", 32'(ld_tx_data), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_gnt", 32'(gnt), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      chk("tie_a_ready", 32'(a_ready), 32'd1);
      chk("tie_b_ready", 32'(b_ready), 32'd0);
      wait_drain("drain_tie");

      // Single byte with a fixed UART response.
      do_reset();
      fix_drop = 2; fix_busy = 10;
      @(negedge clk);
      qa.push_back({8'h41, 1'b0});
      exp_q.push_back({8'h41, 1'b0});
      @(negedge clk);
      chk("single_a_ready", 32'(a_ready), 32'd1);
      base = loads;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         chk("single_ld", 32'(ld_tx_data), 32'(c <= 3));
         if (c <= 3) chk("single_tx_data", 32'(tx_data), 32'h41);
         chk("single_busy", 32'(busy), 32'(c <= 13));
      end
      wait_drain("drain_single");
      chk("single_load_count", 32'(loads - base), 32'd1);
      fix_drop = 0; fix_busy = 0;

      // UART not empty: nothing accepted, then A first.
      do_reset();
      @(negedge clk);
      uart_mode = UM_BUSY;
      qa.push_back({8'hC1, 1'b0});
      qb.push_back({8'hD1, 1'b0});
      exp_q.push_back({8'hC1, 1'b0});
      exp_q.push_back({8'hD1, 1'b1});
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("busy_uart_a_ready", 32'(a_ready), 32'd0);
         chk("busy_uart_b_ready", 32'(b_ready), 32'd0);
         chk("busy_uart_ld", 32'(ld_tx_data), 32'd0);
      end
      uart_mode = UM_NORM;
      @(negedge clk);
      chk("busy_uart_a_first", 32'(a_ready), 32'd1);
      chk("busy_uart_b_wait", 32'(b_ready), 32'd0);
      wait_drain("drain_busy_uart");

      // Round-robin with both ports continuously valid.
      do_reset();
      @(negedge clk);
      for (int n = 0; n < 6; n++) begin
         qa.push_back({8'(8'h30 + n), 1'b0});
         qb.push_back({8'(8'h60 + n), 1'b0});
         exp_q.push_back({8'(8'h30 + n), 1'b0});
         exp_q.push_back({8'(8'h60 + n), 1'b1});
      end
      wait_drain("drain_rr");

      // Lock: A keeps the grant for four bytes while B waits.
      do_reset();
      @(negedge clk);
      base = loads;
      for (int n = 0; n < 4; n++) begin
         qa.push_back({8'(8'hA0 + n), 1'b1});
         exp_q.push_back({8'(8'hA0 + n), 1'b0});
      end
      qb.push_back({8'hB0, 1'b0});
      qb.push_back({8'hB1, 1'b0});
      exp_q.push_back({8'hB0, 1'b1});
      exp_q.push_back({8'hB1, 1'b1});
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (loads - base >= 4) break;
         chk("lock_b_blocked", 32'(b_ready), 32'd0);
      end
      chk("lock_a_loads", 32'(loads - base >= 4), 32'd1);
      wait_drain("drain_lock");

      // Randomized traffic against the transaction-level model.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         dly_max = int'($urandom_range(1, 4));
         busy_max = int'($urandom_range(1, 5));
         @(negedge clk);
         ma.delete();
         mb.delete();
         na = int'($urandom_range(0, 6));
         nb = int'($urandom_range(0, 6));
         for (int i = 0; i < na; i++) begin
            s = {8'($urandom), ($urandom_range(0, 2) == 0)};
            qa.push_back(s);
            ma.push_back(s);
         end
         for (int i = 0; i < nb; i++) begin
            s = {8'($urandom), ($urandom_range(0, 2) == 0)};
            qb.push_back(s);
            mb.push_back(s);
         end
         model_order(ma, mb);
         wait_drain("drain_random");
      end

      // Handshake timeout with the UART stuck empty.
      do_reset();
      @(negedge clk);
      uart_mode = UM_STUCK;
      qa.push_back({8'h55, 1'b0});
      exp_q.push_back({8'h55, 1'b0});
      @(negedge clk);
      chk("to_a_ready", 32'(a_ready), 32'd1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("to_ld_high", 32'(ld_tx_data), 32'd1);
         chk("to_err_low", 32'(err), 32'd0);
         if (c == 2) begin
            qa.push_back({8'h56, 1'b0});
            exp_q.push_back({8'h56, 1'b0});
         end
      end
      @(negedge clk);
      chk("to_ld_drop", 32'(ld_tx_data), 32'd0);
      chk("to_err_set", 32'(err), 32'd1);
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_next_accept", 32'(a_ready), 32'd1);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("to_err_sticky", 32'(err), 32'd1);
      end
      wait_drain("drain_timeout");
      chk("to_err_kept", 32'(err), 32'd1);
      uart_mode = UM_NORM;
      do_reset();
      @(negedge clk);
      chk("to_err_cleared", 32'(err), 32'd0);

      // TIMEOUT of one: a single LOAD cycle, then abort.
      @(posedge clk); #2;
      t1_a_valid = 1'b1; t1_a_data = 8'h9A;
      @(negedge clk);
      chk("t1_a_ready", 32'(t1_a_ready), 32'd1);
      @(posedge clk); #2;
      t1_a_valid = 1'b0;
      @(negedge clk);
      chk("t1_ld", 32'(t1_ld), 32'd1);
      chk("t1_tx_data", 32'(t1_tx_data), 32'h9A);
      @(negedge clk);
      chk("t1_ld_drop", 32'(t1_ld), 32'd0);
      chk("t1_err", 32'(t1_err), 32'd1);
      chk("t1_busy", 32'(t1_busy), 32'd0);

      // Reset while in LOAD with A holding its lock.
      do_reset();
      @(negedge clk);
      uart_mode = UM_STUCK;
      a_lock_idle = 1'b1;
      qa.push_back({8'h77, 1'b1});
      qb.push_back({8'h88, 1'b0});
      exp_q.push_back({8'h77, 1'b0});
      exp_q.push_back({8'h88, 1'b1});
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (a_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("rmid_a_accept", 32'(got), 32'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      @(negedge clk);
      chk("rmid_in_load", 32'(ld_tx_data), 32'd1);
      @(posedge clk); #2;
      reset = 1'b0;
      uart_mode = UM_NORM;
      @(negedge clk);
      chk("rmid_ld", 32'(ld_tx_data), 32'd0);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_tx_data", 32'(tx_data), 32'h00);
      chk("rmid_gnt", 32'(gnt), 32'd1);
      chk("rmid_b_ready", 32'(b_ready), 32'd1);
      chk("rmid_a_ready", 32'(a_ready), 32'd0);
      @(negedge clk);
      a_lock_idle = 1'b0;
      wait_drain("drain_rmid");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
